uart_tx_top: RTL and testbench

Transmit serializer for the UART16550 core, the counterpart of the receive path. It pops characters from the transmit holding FIFO and frames each one: start bit, 5–8 data bits LSB first, optional parity, then 1, 1.5 or 2 stop bits. The frame is driven on `tx` at 16 `baud_pulse` ticks per bit. It shares `baud_pulse` and the line-control fields (`wls`, `pen`, `eps`, `stick_parity`, `stb`, `set_break`) with the receiver.

---
 rtl/uart_pkg.sv | 50 +++++
 rtl/uart_tx_top.sv | 154 +++++++++++++++
 tb/tb_uart_tx_top.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, bit timing, line-control
// field encodings and the parity helper used by the transmit path.
package uart_pkg;

  // Bit-level state machine, shared by the transmitter and the receiver.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // One serial bit lasts this many baud_pulse ticks.
  localparam int TICKS_PER_BIT = 16;
  localparam logic [3:0] TICK_LAST = 4'(TICKS_PER_BIT - 1);
  // Reload for the extra half stop bit (1.5 stop bits).
  localparam logic [3:0] TICK_HALF = 4'(TICKS_PER_BIT / 2 - 1);

  // Word-length select (wls) encodings.
  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  // Parity mode as selected by {stick_parity, eps}.
  typedef enum logic [1:0] {
    PAR_ODD   = 2'b00,
    PAR_EVEN  = 2'b01,
    PAR_MARK  = 2'b10,
    PAR_SPACE = 2'b11
  } par_mode_e;

  // Parity bit over the active data bits only; bits above the word length are masked off.
  function automatic logic parity_bit(input logic [7:0] data,
                                      input logic [1:0] wls,
                                      input par_mode_e  mode);
    logic [7:0] mask;
    logic       x;
    mask = 8'hFF >> (2'd3 - wls);
    x    = ^(data & mask);
    case (mode)
      PAR_ODD:   parity_bit = ~x;
      PAR_EVEN:  parity_bit = x;
      PAR_MARK:  parity_bit = 1'b1;
      default:   parity_bit = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_top.sv
// UART transmit serializer: pops a character from the holding FIFO and
// frames it as start, 5-8 data bits LSB first, optional parity and
// 1 / 1.5 / 2 stop bits, 16 baud ticks per bit.
module uart_tx_top
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud_pulse,
  input  logic       thr_empty,
  input  logic [7:0] din,
  input  logic [1:0] wls,
  input  logic       pen,
  input  logic       eps,
  input  logic       stick_parity,
  input  logic       stb,
  input  logic       set_break,
  output logic       tx,
  output logic       pop,
  output logic       sreg_empty
);

  uart_state_e state_q, state_d;
  logic [3:0]  tick_q, tick_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sreg_q, sreg_d;
  logic        par_q, par_d;             // parity bit, computed at frame load
  logic        pen_q, pen_d;
  logic        stop_ext_q, stop_ext_d;   // frame has more than one stop bit
  logic        stop_short_q, stop_short_d; // extension is half a bit (5-bit words)
  logic        stop2_q, stop2_d;         // currently in the stop extension
  logic        tx_q, tx_d;
  logic        pop_q, pop_d;
  logic        sreg_empty_q, sreg_empty_d;
  logic        stop_done;
  logic        load_frame;

  // Next-state logic: bit timing, shifting, and frame loading.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    tick_d       = tick_q;
    bit_d        = bit_q;
    sreg_d       = sreg_q;
    par_d        = par_q;
    pen_d        = pen_q;
    stop_ext_d   = stop_ext_q;
    stop_short_d = stop_short_q;
    stop2_d      = stop2_q;
    tx_d         = tx_q;
    pop_d        = 1'b0;

    stop_done  = (state_q == ST_STOP) && (tick_q == 4'd0) && (!stop_ext_q || stop2_q);
    load_frame = baud_pulse && !thr_empty && ((state_q == ST_IDLE) || stop_done);

    if (baud_pulse && (state_q != ST_IDLE)) begin
      if (tick_q != 4'd0) begin
        tick_d = tick_q - 4'd1;
      end else begin
        tick_d = TICK_LAST;
        case (state_q)
          ST_START: begin
            state_d = ST_DATA;
            tx_d    = sreg_q[0];
            sreg_d  = {1'b0, sreg_q[7:1]};
          end
          ST_DATA: begin
            if (bit_q != 3'd0) begin
              tx_d   = sreg_q[0];
              sreg_d = {1'b0, sreg_q[7:1]};
              bit_d  = bit_q - 3'd1;
            end else if (pen_q) begin
              state_d = ST_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
              stop2_d = 1'b0;
            end
          end
          ST_PARITY: begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
            stop2_d = 1'b0;
          end
          ST_STOP: begin
            if (stop_ext_q && !stop2_q) begin
              stop2_d = 1'b1;
              tick_d  = stop_short_q ? TICK_HALF : TICK_LAST;
            end else begin
              state_d = ST_IDLE;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end

    // Loading from IDLE or straight out of the last stop tick (no idle gap).
    if (load_frame) begin
      state_d      = ST_START;
      tick_d       = TICK_LAST;
      bit_d        = {1'b1, wls} - 3'd4 + 3'd4; // data bits - 1 = 4 + wls
      sreg_d       = din;
      par_d        = parity_bit(din, wls, par_mode_e'({stick_parity, eps}));
      pen_d        = pen;
      stop_ext_d   = stb;
      stop_short_d = (wls == WLS_5);
      stop2_d      = 1'b0;
      tx_d         = 1'b0;
      pop_d        = 1'b1;
    end

    sreg_empty_d = (state_d == ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      tick_q       <= '0;
      bit_q        <= '0;
      sreg_q       <= '0;
      par_q        <= 1'b0;
      pen_q        <= 1'b0;
      stop_ext_q   <= 1'b0;
      stop_short_q <= 1'b0;
      stop2_q      <= 1'b0;
      tx_q         <= 1'b1;
      pop_q        <= 1'b0;
      sreg_empty_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so all flops update from pre-edge values.
      state_q      <= state_d;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      sreg_q       <= sreg_d;
      par_q        <= par_d;
      pen_q        <= pen_d;
      stop_ext_q   <= stop_ext_d;
      stop_short_q <= stop_short_d;
      stop2_q      <= stop2_d;
      tx_q         <= tx_d;
      pop_q        <= pop_d;
      sreg_empty_q <= sreg_empty_d;
    end
  end

  // Break overrides the line without disturbing the FSM.
  assign tx         = tx_q & ~set_break;
  assign pop        = pop_q;
  assign sreg_empty = sreg_empty_q;

endmodule

// File: tb/tb_uart_tx_top.sv
// Directed bench for uart_tx_top: frames are sampled mid-bit against
// hand-computed bit patterns, with frame length checked via sreg_empty.
module tb_uart_tx_top;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_pulse = 1'b0;
  logic       thr_empty = 1'b1;
  logic [7:0] din = 8'h00;
  logic [1:0] wls = 2'b11;
  logic       pen = 1'b0;
  logic       eps = 1'b0;
  logic       stick_parity = 1'b0;
  logic       stb = 1'b0;
  logic       set_break = 1'b0;
  logic       tx;
  logic       pop;
  logic       sreg_empty;

  int total = 0;
  int bad = 0;
  int tick_cnt = 0;
  int pop_cnt = 0;

  uart_tx_top dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .baud_pulse   (baud_pulse),
    .thr_empty    (thr_empty),
    .din          (din),
    .wls          (wls),
    .pen          (pen),
    .eps          (eps),
    .stick_parity (stick_parity),
    .stb          (stb),
    .set_break    (set_break),
    .tx           (tx),
    .pop          (pop),
    .sreg_empty   (sreg_empty)
  );

  always #5 clk = ~clk;

  // baud_pulse: one clk high out of every 6.
  initial begin
    forever begin
      repeat (5) @(negedge clk);
      baud_pulse = 1'b1;
      @(negedge clk);
      baud_pulse = 1'b0;
    end
  end

  // Count baud edges and pop pulses.
  always @(posedge clk) if (baud_pulse) tick_cnt <= tick_cnt + 1;
  always @(negedge clk) if (pop) pop_cnt <= pop_cnt + 1;

  // Watchdog.
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_tick(input int target, input string tag);
    int budget;
    budget = 20000;
    while (tick_cnt < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (tick_cnt < target) begin
      total++; bad++;
      $display("FAIL %s: timeout waiting for tick %0d, reached %0d", tag, target, tick_cnt);
    end
  endtask

  task automatic wait_pop(input string tag, output int l);
    int budget;
    budget = 2000;
    @(negedge clk);
    while (!pop && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    l = tick_cnt;
    if (!pop) begin
      total++; bad++;
      $display("FAIL %s: no pop seen, got pop=%b required 1", tag, pop);
    end
  endtask

  // Start one frame and release the FIFO as soon as it is popped.
  task automatic run_frame(input string tag, output int l);
    thr_empty = 1'b0;
    wait_pop(tag, l);
    thr_empty = 1'b1;
  endtask

  // Sample tx mid-bit for nbits bits starting at the start bit.
  task automatic capture(input int l, input int nbits, output logic [15:0] bits);
    bits = '0;
    for (int k = 0; k < nbits; k++) begin
      wait_tick(l + 16 * k + 8, "capture");
      bits[k] = tx;
    end
  endtask

  task automatic test_reset();
    thr_empty = 1'b0;
    din = 8'h45;
    repeat (20) @(negedge clk);
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b required 1", tx); end
    total++; if (pop !== 1'b0) begin bad++; $display("FAIL reset_pop: got %b required 0", pop); end
    total++; if (sreg_empty !== 1'b1) begin bad++; $display("FAIL reset_sreg_empty: got %b required 1", sreg_empty); end
    total++; if (pop_cnt !== 0) begin bad++; $display("FAIL reset_no_pop: got %0d pops required 0", pop_cnt); end
    thr_empty = 1'b1;
    rst_n = 1'b1;
    wait_tick(tick_cnt + 3, "reset_idle");
    total++; if (tx !== 1'b1 || sreg_empty !== 1'b1) begin
      bad++; $display("FAIL idle_after_reset: got tx=%b sreg_empty=%b required 1,1", tx, sreg_empty);
    end
  endtask

  // Generic 8-bit-with-parity frame check used by 8E1/8O1/stick scenarios.
  task automatic test_8bit_parity(input string tag, input logic [7:0] d, input logic st,
                                  input logic ep, input logic [10:0] exp_bits);
    int l, p0;
    logic [15:0] bits;
    p0 = pop_cnt;
    din = d; wls = 2'b11; pen = 1'b1; eps = ep; stick_parity = st; stb = 1'b0;
    run_frame(tag, l);
    // Mid-frame line-control changes must not affect the frame.
    eps = ~ep; wls = 2'b00; pen = 1'b0;
    capture(l, 11, bits);
    total++; if (bits[10:0] !== exp_bits) begin
      bad++; $display("FAIL %s_bits: got %b required %b", tag, bits[10:0], exp_bits);
    end
    wait_tick(l + 175, tag);
    total++; if (sreg_empty !== 1'b0) begin bad++; $display("FAIL %s_busy: got sreg_empty=%b required 0", tag, sreg_empty); end
    wait_tick(l + 176, tag);
    total++; if (sreg_empty !== 1'b1) begin bad++; $display("FAIL %s_done: got sreg_empty=%b required 1", tag, sreg_empty); end
    repeat (3) @(negedge clk);
    total++; if (pop_cnt - p0 !== 1) begin bad++; $display("FAIL %s_pops: got %0d required 1", tag, pop_cnt - p0); end
  endtask

  task automatic test_8e1();
    // 0x45 LSB first 1,0,1,0,0,0,1,0; even parity of 3 ones = 1
    test_8bit_parity("8e1", 8'h45, 1'b0, 1'b1, 11'b11010001010);
  endtask

  task automatic test_8o1();
    test_8bit_parity("8o1", 8'h45, 1'b0, 1'b0, 11'b10010001010);
  endtask

  task automatic test_stick_parity();
    // 0x44 has two ones: stick 10 -> parity 1, stick 11 -> parity 0
    test_8bit_parity("stick_mark", 8'h44, 1'b1, 1'b0, 11'b11010001000);
    test_8bit_parity("stick_space", 8'h44, 1'b1, 1'b1, 11'b10010001000);
  endtask

  task automatic test_5bit_15stop();
    int l, p0;
    logic [15:0] bits;
    p0 = pop_cnt;
    din = 8'hF5; wls = 2'b00; pen = 1'b0; eps = 1'b0; stick_parity = 1'b0; stb = 1'b1;
    run_frame("5b", l);
    capture(l, 7, bits);
    total++; if (bits[6:0] !== 7'b1101010) begin bad++; $display("FAIL 5b_bits: got %b required %b", bits[6:0], 7'b1101010); end
    wait_tick(l + 116, "5b");
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL 5b_half_stop: got tx=%b required 1", tx); end
    wait_tick(l + 119, "5b");
    total++; if (sreg_empty !== 1'b0) begin bad++; $display("FAIL 5b_busy: got %b required 0", sreg_empty); end
    wait_tick(l + 120, "5b");
    total++; if (sreg_empty !== 1'b1) begin bad++; $display("FAIL 5b_done: got %b required 1", sreg_empty); end
    repeat (3) @(negedge clk);
    total++; if (pop_cnt - p0 !== 1) begin bad++; $display("FAIL 5b_pops: got %0d required 1", pop_cnt - p0); end
  endtask

  task automatic test_break();
    int l, p0;
    p0 = pop_cnt;
    din = 8'hFF; wls = 2'b11; pen = 1'b0; stick_parity = 1'b0; stb = 1'b0;
    run_frame("brk", l);
    wait_tick(l + 40, "brk");
    set_break = 1'b1;
    #1;
    total++; if (tx !== 1'b0) begin bad++; $display("FAIL brk_immediate: got tx=%b required 0", tx); end
    wait_tick(l + 56, "brk");
    total++; if (tx !== 1'b0) begin bad++; $display("FAIL brk_held: got tx=%b required 0", tx); end
    wait_tick(l + 72, "brk");
    set_break = 1'b0;
    wait_tick(l + 88, "brk");
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL brk_released: got tx=%b required 1", tx); end
    wait_tick(l + 159, "brk");
    total++; if (sreg_empty !== 1'b0) begin bad++; $display("FAIL brk_busy: got %b required 0", sreg_empty); end
    wait_tick(l + 160, "brk");
    total++; if (sreg_empty !== 1'b1) begin bad++; $display("FAIL brk_done: got %b required 1", sreg_empty); end
    repeat (3) @(negedge clk);
    total++; if (pop_cnt - p0 !== 1) begin bad++; $display("FAIL brk_pops: got %0d required 1", pop_cnt - p0); end
  endtask

  task automatic test_back_to_back();
    int l, l2, p0;
    logic [15:0] bits;
    p0 = pop_cnt;
    din = 8'hA5; wls = 2'b11; pen = 1'b0; eps = 1'b0; stick_parity = 1'b0; stb = 1'b0;
    thr_empty = 1'b0;
    wait_pop("b2b_first", l);
    din = 8'h3C;
    wait_tick(l + 24, "b2b");
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL b2b_first_d0: got %b required 1", tx); end
    wait_tick(l + 152, "b2b");
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL b2b_first_stop: got %b required 1", tx); end
    wait_pop("b2b_second", l2);
    thr_empty = 1'b1;
    total++; if (l2 !== l + 160) begin bad++; $display("FAIL b2b_gap: second start at tick %0d required %0d", l2 - l, 160); end
    total++; if (tx !== 1'b0 || sreg_empty !== 1'b0) begin
      bad++; $display("FAIL b2b_start: got tx=%b sreg_empty=%b required 0,0", tx, sreg_empty);
    end
    capture(l2, 10, bits);
    total++; if (bits[9:0] !== 10'b1001111000) begin bad++; $display("FAIL b2b_bits: got %b required %b", bits[9:0], 10'b1001111000); end
    wait_tick(l2 + 160, "b2b");
    total++; if (sreg_empty !== 1'b1) begin bad++; $display("FAIL b2b_done: got %b required 1", sreg_empty); end
    repeat (3) @(negedge clk);
    total++; if (pop_cnt - p0 !== 2) begin bad++; $display("FAIL b2b_pops: got %0d required 2", pop_cnt - p0); end
  endtask

  task automatic test_reset_mid_frame();
    int l, l2, p0;
    logic [15:0] bits;
    p0 = pop_cnt;
    din = 8'h00; wls = 2'b11; pen = 1'b0; stb = 1'b0;
    run_frame("rmf", l);
    wait_tick(l + 40, "rmf");
    total++; if (tx !== 1'b0) begin bad++; $display("FAIL rmf_data: got tx=%b required 0", tx); end
    rst_n = 1'b0;
    #1;
    total++; if (tx !== 1'b1 || sreg_empty !== 1'b1) begin
      bad++; $display("FAIL rmf_async: got tx=%b sreg_empty=%b required 1,1", tx, sreg_empty);
    end
    din = 8'h45;
    thr_empty = 1'b0;
    repeat (10) @(negedge clk);
    total++; if (pop !== 1'b0) begin bad++; $display("FAIL rmf_pop_in_reset: got %b required 0", pop); end
    rst_n = 1'b1;
    wait_pop("rmf_fresh", l2);
    thr_empty = 1'b1;
    capture(l2, 10, bits);
    total++; if (bits[9:0] !== 10'b1010001010) begin bad++; $display("FAIL rmf_bits: got %b required %b", bits[9:0], 10'b1010001010); end
    wait_tick(l2 + 159, "rmf");
    total++; if (sreg_empty !== 1'b0) begin bad++; $display("FAIL rmf_busy: got %b required 0", sreg_empty); end
    wait_tick(l2 + 160, "rmf");
    total++; if (sreg_empty !== 1'b1) begin bad++; $display("FAIL rmf_done: got %b required 1", sreg_empty); end
    repeat (3) @(negedge clk);
    total++; if (pop_cnt - p0 !== 2) begin bad++; $display("FAIL rmf_pops: got %0d required 2", pop_cnt - p0); end
  endtask

  initial begin
    test_reset();
    test_8e1();
    test_8o1();
    test_5bit_15stop();
    test_back_to_back();
    test_stick_parity();
    test_break();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
